// File: rtl/mips_dmem_pkg.sv
// Shared constants for the mips data-memory responder: region select, I/O offsets and
// console status layout.
package mips_dmem_pkg;

  localparam int unsigned IO_SEL_BIT = 31;

  localparam logic [2:0] IO_CYCLE     = 3'd0;
  localparam logic [2:0] IO_CONS_DATA = 3'd1;
  localparam logic [2:0] IO_CONS_STAT = 3'd2;
  localparam logic [2:0] IO_SCRATCH   = 3'd3;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 5;

  function automatic logic [31:0] stat_word(input logic full, input logic empty,
                                            input logic ovf, input logic [STAT_CNT_W-1:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_OVF]   = ovf;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mips_cons_fifo.sv
// Console byte FIFO, pointer-plus-count. Push while full and pop while empty are ignored;
// overflow reporting is left to the parent.
module mips_cons_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               data_in,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Storage is not reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_q] <= data_in;
  end

  assign head  = empty ? 8'h00 : mem[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/mips_dmem_responder.sv
// Single-cycle data-memory responder: word RAM in the low half, MMIO (cycle counter,
// console FIFO, scratch) in the high half. Macro DMEM_CYCLE_COUNTER_EN enables the counter.
module mips_dmem_responder
  import mips_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned CONS_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(CONS_DEPTH) + 1;

  logic          is_io;
  logic [2:0]    io_off;
  logic [AW-1:0] widx;
  logic          ram_we, io_we;
  logic          cons_push, cons_pop, stat_wr, scratch_wr;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic [31:0]   scratch_q;
  logic          ovf_q;
  logic [31:0]   cycle_val;
  logic [31:0]   ram [DEPTH_WORDS];
  logic          unused_addr;

  assign is_io  = addr[IO_SEL_BIT];
  assign io_off = addr[4:2];
  assign widx   = addr[AW+1:2];
  assign unused_addr = ^addr[30:0];

  assign ram_we     = memwrite & ~is_io & ~reset;
  assign io_we      = memwrite & is_io & ~reset;
  assign cons_push  = io_we & (io_off == IO_CONS_DATA);
  assign stat_wr    = io_we & (io_off == IO_CONS_STAT);
  assign scratch_wr = io_we & (io_off == IO_SCRATCH);
  assign cons_pop   = cons_valid & cons_ready;

  always_ff @(posedge clk) begin
    if (ram_we) ram[widx] <= writedata;
  end

  // Full is judged on pre-edge state, so a push into a full FIFO is lost even alongside a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (scratch_wr) scratch_q <= writedata;
      if (stat_wr) begin
        ovf_q <= 1'b0;
      end else if (cons_push && fifo_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  mips_cons_fifo #(
    .DEPTH (CONS_DEPTH)
  ) u_cons_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cons_push),
    .data_in (writedata[7:0]),
    .pop     (cons_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign cons_valid = ~fifo_empty;
  assign cons_data  = fifo_head;

  always_comb begin
    readdata = '0;
    if (!is_io) begin
      readdata = ram[widx];
    end else begin
      case (io_off)
        IO_CYCLE:     readdata = cycle_val;
        IO_CONS_STAT: readdata = stat_word(fifo_full, fifo_empty, ovf_q,
                                           STAT_CNT_W'(fifo_count));
        IO_SCRATCH:   readdata = scratch_q;
        default:      readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: directed scenarios then random traffic, all checked against
// a queue/array reference model.
module tb_mips_dmem_responder;

  localparam int DW = 64;
  localparam int CD = 8;

  logic        clk = 1'b0;
  logic        reset, memwrite, cons_ready, cons_valid;
  logic [31:0] addr, writedata, readdata;
  logic [7:0]  cons_data;

  always #5 clk = ~clk;

  mips_dmem_responder #(
    .DEPTH_WORDS (DW),
    .CONS_DEPTH  (CD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .writedata  (writedata),
    .memwrite   (memwrite),
    .readdata   (readdata),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .cons_ready (cons_ready)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mram   [DW];
  bit          mvalid [DW];
  logic [7:0]  q [$];
  logic [31:0] mscratch, mcycle;
  bit          movf;

  function automatic logic [31:0] exp_cycle(input logic [31:0] n);
`ifdef DMEM_CYCLE_COUNTER_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int n;
    if (!a[31]) return mram[int'((a >> 2) % DW)];
    n = q.size();
    case (int'((a >> 2) & 32'd7))
      0: return exp_cycle(mcycle);
      2: return {23'b0, 5'(n), 1'b0, movf, (n == 0), (n == CD)};
      3: return mscratch;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic rdy, input logic rst, input string tag,
                      output logic [31:0] rd);
    int  idx;
    bit  pop, full_pre;
    addr = a; writedata = wd; memwrite = we; cons_ready = rdy; reset = rst;
    #3;
    rd  = readdata;
    idx = int'((a >> 2) % DW);
    if (a[31] || mvalid[idx]) check({tag, "/rd"}, readdata, model_read(a));
    check({tag, "/valid"}, {31'b0, cons_valid}, {31'b0, q.size() != 0});
    check({tag, "/data"}, {24'b0, cons_data}, {24'b0, (q.size() != 0) ? q[0] : 8'h00});
    @(posedge clk);
    if (rst) begin
      q.delete();
      mscratch = 0; movf = 0; mcycle = 0;
    end else begin
      pop      = (q.size() != 0) && rdy;
      full_pre = (q.size() == CD);
      if (pop) void'(q.pop_front());
      if (we && !a[31]) begin
        mram[idx] = wd; mvalid[idx] = 1;
      end else if (we) begin
        case (int'((a >> 2) & 32'd7))
          1: if (full_pre) movf = 1; else q.push_back(wd[7:0]);
          2: movf = 0;
          3: mscratch = wd;
          default: ;
        endcase
      end
      mcycle++;
    end
    #1;
  endtask

  logic [31:0] rd;
  localparam logic [31:0] STAT = 32'h8000_0008;
  localparam logic [31:0] CONS = 32'h8000_0004;

  initial begin
    reset = 1'b1; memwrite = 1'b0; cons_ready = 1'b0; addr = '0; writedata = '0;
    @(posedge clk);
    #1;
    q.delete(); mscratch = 0; movf = 0; mcycle = 0;

    // Reset state and cycle counter after release
    step(32'h8000_0000, 0, 0, 0, 0, "cyc1", rd); check("cyc1_val", rd, exp_cycle(0));
    step(32'h8000_0000, 0, 0, 0, 0, "cyc2", rd); check("cyc2_val", rd, exp_cycle(1));
    step(STAT, 0, 0, 0, 0, "rst_stat", rd);      check("rst_stat_val", rd, 32'h2);
    step(32'h8000_000C, 0, 0, 0, 0, "rst_scr", rd); check("rst_scr_val", rd, 32'h0);
    step(32'h8000_0000, 0, 0, 0, 0, "cyc5", rd); check("cyc5_val", rd, exp_cycle(4));

    // Fill RAM so every word is known
    for (int i = 0; i < DW; i++) step(i * 4, $urandom, 1, 0, 0, "fill", rd);

    // Store/load and alias
    step(32'h10, 32'hDEAD_BEEF, 1, 0, 0, "st10", rd);
    step(32'h10, 0, 0, 0, 0, "ld10", rd);   check("ld10_val", rd, 32'hDEAD_BEEF);
    step(32'h13, 0, 0, 0, 0, "ld13", rd);   check("ld13_val", rd, 32'hDEAD_BEEF);
    step(32'h110, 0, 0, 0, 0, "ld110", rd); check("alias_val", rd, 32'hDEAD_BEEF);

    // Console ordering
    step(CONS, 32'h41, 1, 0, 0, "push41", rd);
    step(CONS, 32'h42, 1, 0, 0, "push42", rd);
    step(CONS, 32'h43, 1, 0, 0, "push43", rd);
    step(STAT, 0, 0, 0, 0, "stat3", rd); check("stat3_val", rd, 32'h30);
    check("head41", {24'b0, cons_data}, 32'h41);
    for (int i = 0; i < 4; i++) step(CONS, 0, 0, 1, 0, "drain", rd);
    check("drained", {31'b0, cons_valid}, 32'h0);

    // Overflow
    for (int i = 0; i < 9; i++) step(CONS, 32'h60 + i, 1, 0, 0, "ovpush", rd);
    step(STAT, 0, 0, 0, 0, "ovstat", rd); check("ovstat_val", rd, 32'h85);
    step(STAT, 0, 1, 0, 0, "ovclr", rd);
    step(STAT, 0, 0, 0, 0, "clrstat", rd); check("clrstat_val", rd, 32'h81);
    step(CONS, 32'hEE, 1, 1, 0, "fullpushpop", rd);
    step(STAT, 0, 0, 0, 0, "fpp_stat", rd); check("fpp_stat_val", rd, 32'h74);

    // Scratch and holes
    step(32'h8000_000C, 32'h1234_5678, 1, 0, 0, "scr_wr", rd);
    step(32'h8000_000C, 0, 0, 0, 0, "scr_rd", rd); check("scr_val", rd, 32'h1234_5678);
    step(32'h8000_0004, 0, 0, 0, 0, "hole4", rd);  check("hole4_val", rd, 32'h0);
    step(32'h8000_0014, 0, 0, 0, 0, "hole14", rd); check("hole14_val", rd, 32'h0);

    // Reset mid-stream
    step(32'h8000_000C, 32'h5, 1, 0, 0, "scr5", rd);
    step(32'h10, 32'h1111_2222, 1, 0, 1, "rst_mid", rd);
    step(STAT, 0, 0, 0, 0, "post_stat", rd); check("post_stat_val", rd, 32'h2);
    check("post_valid", {31'b0, cons_valid}, 32'h0);
    step(32'h8000_000C, 0, 0, 0, 0, "post_scr", rd); check("post_scr_val", rd, 32'h0);
    step(32'h10, 0, 0, 0, 0, "post_ram", rd); check("post_ram_val", rd, 32'hDEAD_BEEF);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 1) == 0) a = {1'b0, 31'($urandom)};
      else a = {1'b1, 26'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
      step(a, $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0), "rand", rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
